fb_triple_buffer_ctrl: RTL and testbench
========================================

Name: fb_triple_buffer_ctrl

Overview:
- Manages three frame-buffer banks shared between a frame writer (capture/DMA) and the HDMI display timing generator.
- Tracks which bank is displayed, which is being written, and which holds the newest completed frame.
- Swaps banks only at the start of vertical blanking, so the display never tears.
- Drives the bank base addresses to the writer and the display address path.

Parameters:
- BANK_WORDS, 153600, words per bank (640*480/2, two pixels per word)
- ADDR_W, 20, width of base-address outputs; must hold 3*BANK_WORDS-1
- CNT_W, 16, width of the statistics counters

Ports:
- clk24  input  1  pixel-pair clock
- rst  input  1  synchronous reset, active-high
- disp_vblank  input  1  level; high during display vertical blanking
- wr_frame_start  input  1  one-cycle pulse; writer begins a frame
- wr_frame_done  input  1  one-cycle pulse; writer completed a frame
- wr_abort  input  1  one-cycle pulse; writer discards the current frame
- disp_bank  output  2  bank being displayed (0..2)
- wr_bank  output  2  bank the writer targets (0..2)
- disp_base_addr  output  ADDR_W  disp_bank*BANK_WORDS
- wr_base_addr  output  ADDR_W  wr_bank*BANK_WORDS
- wr_busy  output  1  writer FSM in WRITING
- new_frame  output  1  one-cycle pulse; display switched to a new bank
- frames_dropped  output  CNT_W  completed frames overwritten before display (saturating)
- frames_repeated  output  CNT_W  vblanks with no new frame (saturating)

Behaviour:
- State registers: disp_bank, wr_bank, rdy_bank, rdy_valid, vblank_q, writer FSM.
- Invariant: {disp_bank, wr_bank, rdy_bank} is always a permutation of {0,1,2}.
- Reset values (sync, rst=1):
  - disp_bank=0, wr_bank=1, rdy_bank=2, rdy_valid=0
  - FSM=IDLE, wr_busy=0, new_frame=0
  - both counters=0
  - disp_base_addr=0, wr_base_addr=BANK_WORDS
  - vblank_q=1, so no false edge fires if vblank is already high at reset release
- Reset mid-frame discards all progress. No event is recognised in a cycle where rst=1.
- vblank_rise = disp_vblank & ~vblank_q. vblank_q is registered every cycle.
- Writer FSM, IDLE:
  - wr_frame_start -> WRITING.
  - wr_frame_done and wr_abort are ignored.
- Writer FSM, WRITING:
  - wr_frame_done -> IDLE and completes the frame.
  - wr_abort -> IDLE with no bank change.
  - wr_frame_start is ignored.
  - Priority: done > abort.
- Writer completion only (no vblank_rise):
  - Swap wr_bank <-> rdy_bank and set rdy_valid=1.
  - If rdy_valid was already 1, frames_dropped increments.
- vblank_rise only:
  - If rdy_valid=1: swap disp_bank <-> rdy_bank, clear rdy_valid, pulse new_frame.
  - Otherwise frames_repeated increments.
  - A write in progress is unaffected.
- Completion and vblank_rise in the same cycle (three-way rotation):
  - disp_bank <= old wr_bank; wr_bank <= old rdy_bank; rdy_bank <= old disp_bank.
  - rdy_valid <= 0 and new_frame pulses.
  - frames_dropped increments if the old rdy_valid was 1.
- Base addresses are registered and computed from next-state bank values, so each changes in the same cycle as its bank output (zero extra latency).
  - Arithmetic: bank*BANK_WORDS, zero-extended to ADDR_W.
- Counters saturate at all-ones; no wrap.
- wr_busy=1 exactly while FSM=WRITING. It drops in the cycle after the done/abort pulse.

Test Plan:
- Reset release with disp_vblank=1 held -> no new_frame. disp_bank=0, wr_bank=1, wr_base_addr=153600, frames_repeated stays 0 until the next rising edge.
- Start, then done 100 cycles later, then vblank rise ->
  - After done: wr_bank=2, rdy_valid=1.
  - On the rise cycle+1: disp_bank=1, disp_base_addr=153600, new_frame high for exactly 1 cycle.
- Two complete write frames with no vblank between -> frames_dropped=1. The next vblank displays the second frame's bank; the first frame's bank becomes wr_bank.
- wr_frame_done and vblank_rise in the same cycle from reset state (disp0, wr1, rdy2, rdy_valid=0) -> disp=1, wr=2, rdy=0, new_frame=1, frames_dropped=0.
- Start, then wr_abort -> banks unchanged, wr_busy 1->0. A subsequent vblank gives frames_repeated=1 and new_frame=0. A done pulse in IDLE is ignored.
- frames_repeated preset near saturation by driving 65536 vblanks with no writes -> reads 0xFFFF and holds. Assert rst mid-WRITING -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/fb_triple_buffer_ctrl.sv
// Triple-buffer bank controller: rotates three frame-buffer banks between a
// frame writer and the display so that the display switches only at the start
// of vertical blanking and never shows a partially written frame.
module fb_triple_buffer_ctrl #(
    parameter int unsigned BANK_WORDS = 153600,
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk24,
    input  logic              rst,
    input  logic              disp_vblank,
    input  logic              wr_frame_start,
    input  logic              wr_frame_done,
    input  logic              wr_abort,
    output logic [1:0]        disp_bank,
    output logic [1:0]        wr_bank,
    output logic [ADDR_W-1:0] disp_base_addr,
    output logic [ADDR_W-1:0] wr_base_addr,
    output logic              wr_busy,
    output logic              new_frame,
    output logic [CNT_W-1:0]  frames_dropped,
    output logic [CNT_W-1:0]  frames_repeated
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_WRITING = 1'b1
    } wr_state_e;

    wr_state_e         state_q, state_d;
    logic [1:0]        disp_bank_q, disp_bank_d;
    logic [1:0]        wr_bank_q, wr_bank_d;
    logic [1:0]        rdy_bank_q, rdy_bank_d;
    logic              rdy_valid_q, rdy_valid_d;
    logic              vblank_q, vblank_d;
    logic              wr_busy_q, wr_busy_d;
    logic              new_frame_q, new_frame_d;
    logic [CNT_W-1:0]  dropped_q, dropped_d;
    logic [CNT_W-1:0]  repeated_q, repeated_d;
    logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              vblank_rise;
    logic              frame_complete;

    // Base address of a bank; only banks 0..2 ever occur.
    function automatic logic [ADDR_W-1:0] bank_base(input logic [1:0] bank);
        case (bank)
            2'd1:    return ADDR_W'(BANK_WORDS);
            2'd2:    return ADDR_W'(2 * BANK_WORDS);
            default: return '0;
        endcase
    endfunction

    // Counter increment that holds at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Writer FSM, bank rotation, statistics and next-state base addresses.
    always_comb begin
        state_d     = state_q;
        disp_bank_d = disp_bank_q;
        wr_bank_d   = wr_bank_q;
        rdy_bank_d  = rdy_bank_q;
        rdy_valid_d = rdy_valid_q;
        vblank_d    = disp_vblank;
        new_frame_d = 1'b0;
        dropped_d   = dropped_q;
        repeated_d  = repeated_q;

        vblank_rise    = disp_vblank & ~vblank_q;
        frame_complete = (state_q == ST_WRITING) && wr_frame_done;

        case (state_q)
            ST_IDLE: begin
                if (wr_frame_start) state_d = ST_WRITING;
            end
            ST_WRITING: begin
                if (wr_frame_done || wr_abort) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (frame_complete && vblank_rise) begin
            // Fresh frame goes straight to display; old display bank becomes spare.
            disp_bank_d = wr_bank_q;
            wr_bank_d   = rdy_bank_q;
            rdy_bank_d  = disp_bank_q;
            rdy_valid_d = 1'b0;
            new_frame_d = 1'b1;
            if (rdy_valid_q) dropped_d = sat_inc(dropped_q);
        end else if (frame_complete) begin
            wr_bank_d   = rdy_bank_q;
            rdy_bank_d  = wr_bank_q;
            rdy_valid_d = 1'b1;
            if (rdy_valid_q) dropped_d = sat_inc(dropped_q);
        end else if (vblank_rise) begin
            if (rdy_valid_q) begin
                disp_bank_d = rdy_bank_q;
                rdy_bank_d  = disp_bank_q;
                rdy_valid_d = 1'b0;
                new_frame_d = 1'b1;
            end else begin
                repeated_d = sat_inc(repeated_q);
            end
        end

        wr_busy_d   = (state_d == ST_WRITING);
        disp_addr_d = bank_base(disp_bank_d);
        wr_addr_d   = bank_base(wr_bank_d);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk24) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            disp_bank_q <= 2'd0;
            wr_bank_q   <= 2'd1;
            rdy_bank_q  <= 2'd2;
            rdy_valid_q <= 1'b0;
            vblank_q    <= 1'b1;
            wr_busy_q   <= 1'b0;
            new_frame_q <= 1'b0;
            dropped_q   <= '0;
            repeated_q  <= '0;
            disp_addr_q <= '0;
            wr_addr_q   <= ADDR_W'(BANK_WORDS);
        end else begin
            state_q     <= state_d;
            disp_bank_q <= disp_bank_d;
            wr_bank_q   <= wr_bank_d;
            rdy_bank_q  <= rdy_bank_d;
            rdy_valid_q <= rdy_valid_d;
            vblank_q    <= vblank_d;
            wr_busy_q   <= wr_busy_d;
            new_frame_q <= new_frame_d;
            dropped_q   <= dropped_d;
            repeated_q  <= repeated_d;
            disp_addr_q <= disp_addr_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    assign disp_bank       = disp_bank_q;
    assign wr_bank         = wr_bank_q;
    assign disp_base_addr  = disp_addr_q;
    assign wr_base_addr    = wr_addr_q;
    assign wr_busy         = wr_busy_q;
    assign new_frame       = new_frame_q;
    assign frames_dropped  = dropped_q;
    assign frames_repeated = repeated_q;

endmodule

// File: tb/tb_fb_triple_buffer_ctrl.sv
// Directed bench for fb_triple_buffer_ctrl: a cycle table from reset plus
// hand-written long-frame and counter-saturation sequences.
module tb_fb_triple_buffer_ctrl;

    localparam logic [19:0] BW = 20'd153600;
    localparam logic [19:0] B2 = 20'd307200;

    logic        clk24 = 1'b0;
    logic        rst = 1'b1;
    logic        disp_vblank = 1'b1;
    logic        wr_frame_start = 1'b0;
    logic        wr_frame_done = 1'b0;
    logic        wr_abort = 1'b0;
    logic [1:0]  disp_bank, wr_bank;
    logic [19:0] disp_base_addr, wr_base_addr;
    logic        wr_busy, new_frame;
    logic [15:0] frames_dropped, frames_repeated;

    // Second instance with narrow counters for the saturation check.
    logic        s_vblank = 1'b0;
    logic        s_zero = 1'b0;
    logic [1:0]  s_disp_bank, s_wr_bank;
    logic [19:0] s_disp_addr, s_wr_addr;
    logic        s_busy, s_new_frame;
    logic [3:0]  s_dropped, s_repeated;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk24 = ~clk24;

    fb_triple_buffer_ctrl dut (
        .clk24(clk24), .rst(rst), .disp_vblank(disp_vblank),
        .wr_frame_start(wr_frame_start), .wr_frame_done(wr_frame_done),
        .wr_abort(wr_abort), .disp_bank(disp_bank), .wr_bank(wr_bank),
        .disp_base_addr(disp_base_addr), .wr_base_addr(wr_base_addr),
        .wr_busy(wr_busy), .new_frame(new_frame),
        .frames_dropped(frames_dropped), .frames_repeated(frames_repeated)
    );

    fb_triple_buffer_ctrl #(.BANK_WORDS(153600), .ADDR_W(20), .CNT_W(4)) dut_sat (
        .clk24(clk24), .rst(rst), .disp_vblank(s_vblank),
        .wr_frame_start(s_zero), .wr_frame_done(s_zero),
        .wr_abort(s_zero), .disp_bank(s_disp_bank), .wr_bank(s_wr_bank),
        .disp_base_addr(s_disp_addr), .wr_base_addr(s_wr_addr),
        .wr_busy(s_busy), .new_frame(s_new_frame),
        .frames_dropped(s_dropped), .frames_repeated(s_repeated)
    );

    typedef struct {
        logic        rst, vb, st, dn, ab;
        logic [1:0]  disp, wr;
        logic        busy, nf;
        logic [15:0] drop, rep;
        logic [19:0] da, wa;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, vb, st, dn, ab,
                                input logic [1:0] disp, wr,
                                input logic busy, nf,
                                input logic [15:0] drop, rep,
                                input logic [19:0] da, wa);
        vec_t v;
        v.rst = r; v.vb = vb; v.st = st; v.dn = dn; v.ab = ab;
        v.disp = disp; v.wr = wr; v.busy = busy; v.nf = nf;
        v.drop = drop; v.rep = rep; v.da = da; v.wa = wa;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, then sample just after the rising edge.
    task automatic drive(input logic r, vb, st, dn, ab);
        @(negedge clk24);
        rst = r; disp_vblank = vb; wr_frame_start = st;
        wr_frame_done = dn; wr_abort = ab;
        @(posedge clk24);
        #1;
    endtask

    task automatic check_all(input int idx, input vec_t v);
        check("disp_bank", idx, 32'(disp_bank), 32'(v.disp));
        check("wr_bank", idx, 32'(wr_bank), 32'(v.wr));
        check("wr_busy", idx, 32'(wr_busy), 32'(v.busy));
        check("new_frame", idx, 32'(new_frame), 32'(v.nf));
        check("frames_dropped", idx, 32'(frames_dropped), 32'(v.drop));
        check("frames_repeated", idx, 32'(frames_repeated), 32'(v.rep));
        check("disp_base_addr", idx, 32'(disp_base_addr), 32'(v.da));
        check("wr_base_addr", idx, 32'(wr_base_addr), 32'(v.wa));
    endtask

    initial begin
        //               rst vb st dn ab  disp wr busy nf drop rep da  wa
        tbl.push_back(mk(1, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0,  BW)); // reset, vblank high
        tbl.push_back(mk(0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0,  BW)); // no false edge
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0,  BW));
        tbl.push_back(mk(0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 1, 0,  BW)); // repeat
        tbl.push_back(mk(0, 1, 1, 0, 0,  0, 1, 1, 0, 0, 1, 0,  BW)); // start
        tbl.push_back(mk(0, 0, 0, 1, 0,  0, 2, 0, 0, 0, 1, 0,  B2)); // done: wr<->rdy
        tbl.push_back(mk(0, 1, 0, 0, 0,  1, 2, 0, 1, 0, 1, BW, B2)); // flip to display
        tbl.push_back(mk(0, 1, 0, 0, 0,  1, 2, 0, 0, 0, 1, BW, B2)); // pulse ends
        tbl.push_back(mk(0, 0, 1, 0, 0,  1, 2, 1, 0, 0, 1, BW, B2));
        tbl.push_back(mk(0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 1, BW, 0 )); // frame A in bank 2
        tbl.push_back(mk(0, 0, 1, 0, 0,  1, 0, 1, 0, 0, 1, BW, 0 ));
        tbl.push_back(mk(0, 0, 0, 1, 0,  1, 2, 0, 0, 1, 1, BW, B2)); // frame B drops A
        tbl.push_back(mk(0, 1, 0, 0, 0,  0, 2, 0, 1, 1, 1, 0,  B2)); // display frame B
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 2, 0, 0, 1, 1, 0,  B2));
        tbl.push_back(mk(0, 0, 1, 0, 0,  0, 2, 1, 0, 1, 1, 0,  B2));
        tbl.push_back(mk(0, 0, 1, 0, 0,  0, 2, 1, 0, 1, 1, 0,  B2)); // start ignored
        tbl.push_back(mk(0, 0, 0, 0, 1,  0, 2, 0, 0, 1, 1, 0,  B2)); // abort
        tbl.push_back(mk(0, 0, 0, 1, 0,  0, 2, 0, 0, 1, 1, 0,  B2)); // done in IDLE
        tbl.push_back(mk(0, 1, 0, 0, 0,  0, 2, 0, 0, 1, 2, 0,  B2)); // repeat
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 2, 0, 0, 1, 2, 0,  B2));
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0,  BW)); // reset
        tbl.push_back(mk(0, 0, 1, 0, 0,  0, 1, 1, 0, 0, 0, 0,  BW));
        tbl.push_back(mk(0, 1, 0, 1, 0,  1, 2, 0, 1, 0, 0, BW, B2)); // done + rise
        tbl.push_back(mk(0, 1, 0, 0, 0,  1, 2, 0, 0, 0, 0, BW, B2));
        tbl.push_back(mk(0, 0, 1, 0, 0,  1, 2, 1, 0, 0, 0, BW, B2));
        tbl.push_back(mk(0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, BW, 0 )); // rdy was bank 0
        tbl.push_back(mk(0, 0, 1, 0, 0,  1, 0, 1, 0, 0, 0, BW, 0 ));
        tbl.push_back(mk(1, 1, 0, 1, 0,  0, 1, 0, 0, 0, 0, 0,  BW)); // reset mid-write
        tbl.push_back(mk(0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0,  BW));
        tbl.push_back(mk(0, 0, 1, 0, 0,  0, 1, 1, 0, 0, 0, 0,  BW));
        tbl.push_back(mk(0, 0, 0, 1, 1,  0, 2, 0, 0, 0, 0, 0,  B2)); // done beats abort
        tbl.push_back(mk(0, 1, 0, 0, 0,  1, 2, 0, 1, 0, 0, BW, B2)); // ready was valid

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].vb, tbl[i].st, tbl[i].dn, tbl[i].ab);
            check_all(i, tbl[i]);
        end

        // Long frame: start, done 100 cycles later, then a vblank rise.
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        check("long_busy_start", 100, 32'(wr_busy), 32'd1);
        for (int i = 0; i < 99; i++) drive(0, 0, 0, 0, 0);
        check("long_busy_hold", 101, 32'(wr_busy), 32'd1);
        drive(0, 0, 0, 1, 0);
        check("long_wr_bank", 102, 32'(wr_bank), 32'd2);
        check("long_busy_end", 103, 32'(wr_busy), 32'd0);
        check("long_disp_hold", 104, 32'(disp_bank), 32'd0);
        drive(0, 1, 0, 0, 0);
        check("long_disp_bank", 105, 32'(disp_bank), 32'd1);
        check("long_disp_addr", 106, 32'(disp_base_addr), 32'(BW));
        check("long_new_frame", 107, 32'(new_frame), 32'd1);
        drive(0, 1, 0, 0, 0);
        check("long_new_frame_end", 108, 32'(new_frame), 32'd0);
        check("long_repeated", 109, 32'(frames_repeated), 32'd0);

        // Saturation of the narrow repeat counter over 20 vblanks.
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk24); s_vblank = 1'b1;
            @(posedge clk24); #1;
            check("sat_repeated", 200 + i, 32'(s_repeated), (i > 15) ? 32'd15 : 32'(i));
            @(negedge clk24); s_vblank = 1'b0;
            @(posedge clk24); #1;
        end
        check("sat_new_frame", 221, 32'(s_new_frame), 32'd0);
        check("sat_dropped", 222, 32'(s_dropped), 32'd0);
        check("sat_disp_bank", 223, 32'(s_disp_bank), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
